uart_tx_gen: RTL and testbench

UART_TX_GEN -- requirements
Module: uart_tx_gen

---
 rtl/uart_gen_pkg.sv | 22 ++
 rtl/uart_baud_cnt.sv | 36 +++
 rtl/uart_tx_gen.sv | 154 +++++++++++++++
 tb/tb_uart_tx_gen.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/uart_gen_pkg.sv
// rtl/uart_gen_pkg.sv - UART state encoding and parity constants shared by tx and rx
// The BREAK state is only present when UART_TX_BREAK_EN is defined.
package uart_gen_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
      ,BREAK = 3'd5
`endif
   } uart_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Wide enough for DATA_WIDTH+4 break bit periods at DATA_WIDTH=9
   localparam int CNT_W = 4;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - per-bit down-counter with bit-end strobe
// start_i loads a fresh period; while running the counter auto-reloads at zero.
module uart_baud_cnt #(
   parameter int W = 6
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         run_i,
   input  logic         start_i,
   input  logic [W-1:0] start_val_i,
   input  logic [W-1:0] period_m1_i,
   output logic         bit_end_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = '0;
      if (start_i) begin
         cnt_d = start_val_i;
      end else if (run_i) begin
         cnt_d = (cnt_q == '0) ? period_m1_i : cnt_q - W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_end_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_gen.sv
// rtl/uart_tx_gen.sv - UART transmitter with optional parity and 1/2 stop bits
// Defining UART_TX_BREAK_EN adds the BREAK_REQ input and line-break generation.
module uart_tx_gen
   import uart_gen_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   output logic                  DATA_READY,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP_2,
   input  logic [PRESCALE_W-1:0] Prescale,
`ifdef UART_TX_BREAK_EN
   input  logic                  BREAK_REQ,
`endif
   output logic                  TX_OUT,
   output logic                  busy
);

   uart_state_e           state_q, state_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic                  par_q, par_d;
   logic                  par_en_q, par_en_d;
   logic                  stop2_q, stop2_d;
   logic [PRESCALE_W-1:0] per_m1_q, per_m1_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  bit_end, start_bit, last_stop, xfer;
   logic [PRESCALE_W-1:0] presc_m1;

   assign presc_m1   = (Prescale == '0) ? '0 : Prescale - PRESCALE_W'(1);
   assign last_stop  = (state_q == STOP) && bit_end && (bit_cnt_q == CNT_W'(stop2_q));
   assign DATA_READY = !RST && ((state_q == IDLE) || last_stop);
   assign xfer       = DATA_VALID && DATA_READY;

   uart_baud_cnt #(.W(PRESCALE_W)) u_baud (
      .CLK         (CLK),
      .RST         (RST),
      .run_i       (state_q != IDLE),
      .start_i     (start_bit),
      .start_val_i (presc_m1),
      .period_m1_i (per_m1_q),
      .bit_end_o   (bit_end)
   );

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      par_d     = par_q;
      par_en_d  = par_en_q;
      stop2_d   = stop2_q;
      per_m1_d  = per_m1_q;
      start_bit = 1'b0;

      if (xfer) begin
         state_d   = START;
         bit_cnt_d = '0;
         shreg_d   = P_DATA;
         par_d     = (^P_DATA) ^ (PAR_TYP == PAR_ODD);
         par_en_d  = PAR_EN;
         stop2_d   = STOP_2;
         per_m1_d  = presc_m1;
         start_bit = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
`ifdef UART_TX_BREAK_EN
               if (BREAK_REQ) begin
                  state_d   = BREAK;
                  bit_cnt_d = '0;
                  per_m1_d  = presc_m1;
                  start_bit = 1'b1;
               end
`endif
            end
            START: if (bit_end) state_d = DATA;
            DATA: begin
               if (bit_end) begin
                  shreg_d = shreg_q >> 1;
                  if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                     bit_cnt_d = '0;
                     state_d   = par_en_q ? PARITY : STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  end
               end
            end
            PARITY: if (bit_end) state_d = STOP;
            STOP: begin
               if (bit_end) begin
                  if (bit_cnt_q == CNT_W'(stop2_q)) state_d = IDLE;
                  else bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
`ifdef UART_TX_BREAK_EN
            BREAK: begin
               if (bit_end) begin
                  if (bit_cnt_q == CNT_W'(DATA_WIDTH + 4)) state_d = IDLE;
                  else bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
`endif
            default: state_d = IDLE;
         endcase
      end

      // Line level is registered from the next state so it changes with the state itself
      case (state_d)
         START:  tx_d = 1'b0;
         DATA:   tx_d = shreg_d[0];
         PARITY: tx_d = par_d;
`ifdef UART_TX_BREAK_EN
         BREAK:  tx_d = (bit_cnt_d < CNT_W'(DATA_WIDTH + 4)) ? 1'b0 : 1'b1;
`endif
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         par_q     <= 1'b0;
         par_en_q  <= 1'b0;
         stop2_q   <= 1'b0;
         per_m1_q  <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         par_q     <= par_d;
         par_en_q  <= par_en_d;
         stop2_q   <= stop2_d;
         per_m1_q  <= per_m1_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   assign TX_OUT = tx_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_gen.sv
// tb/tb_uart_tx_gen.sv - scoreboard bench for uart_tx_gen (break tests under UART_TX_BREAK_EN)
module tb_uart_tx_gen;
   localparam int DW = 8;
   localparam int PW = 6;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [DW-1:0] P_DATA = '0;
   logic          DATA_VALID = 1'b0;
   logic          DATA_READY;
   logic          PAR_EN = 1'b0, PAR_TYP = 1'b0, STOP_2 = 1'b0;
   logic [PW-1:0] Prescale = '0;
   logic          BREAK_REQ = 1'b0;
   logic          TX_OUT, busy;

   typedef struct {
      logic tx;
      logic busy;
      logic rdy;
   } samp_t;

   samp_t exp_q[$];
   samp_t mon_e;
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   bit    mon_en = 1'b0;

   always #5 CLK = ~CLK;

   uart_tx_gen #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .DATA_READY (DATA_READY),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .STOP_2     (STOP_2),
      .Prescale   (Prescale),
`ifdef UART_TX_BREAK_EN
      .BREAK_REQ  (BREAK_REQ),
`endif
      .TX_OUT     (TX_OUT),
      .busy       (busy)
   );

   // Expected line waveform: one sample per CLK cycle, starting the cycle after transfer
   function automatic void push_frame(input logic [DW-1:0] d, input bit pe, input bit pt,
                                      input bit s2, input int ps);
      int per = (ps == 0) ? 1 : ps;
      bit bits[$];
      samp_t s;
      bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) bits.push_back(d[i]);
      if (pe) bits.push_back((($countones(d) % 2) == 1) ^ pt);
      bits.push_back(1'b1);
      if (s2) bits.push_back(1'b1);
      for (int b = 0; b < bits.size(); b++) begin
         for (int k = 0; k < per; k++) begin
            s.tx = bits[b]; s.busy = 1'b1;
            s.rdy = (b == bits.size() - 1) && (k == per - 1);
            exp_q.push_back(s);
         end
      end
   endfunction

   function automatic void push_break(input int ps);
      int per = (ps == 0) ? 1 : ps;
      samp_t s;
      for (int k = 0; k < (DW + 5) * per; k++) begin
         s.tx = (k >= (DW + 4) * per); s.busy = 1'b1; s.rdy = 1'b0;
         exp_q.push_back(s);
      end
   endfunction

   always @(posedge CLK) begin
      #1;
      cyc++;
      if (mon_en) begin
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
         end else begin
            mon_e.tx = 1'b1; mon_e.busy = 1'b0; mon_e.rdy = 1'b1;
         end
         if (RST) mon_e.rdy = 1'b0;
         checks++;
         if ({TX_OUT, busy, DATA_READY} !== {mon_e.tx, mon_e.busy, mon_e.rdy}) begin
            errors++;
            $display("FAIL line cyc=%0d tx/busy/rdy got=%b%b%b exp=%b%b%b", cyc,
                     TX_OUT, busy, DATA_READY, mon_e.tx, mon_e.busy, mon_e.rdy);
         end
      end
   end

   task automatic drive_frame(input logic [DW-1:0] d, input bit pe, input bit pt,
                              input bit s2, input int ps, input bit brk);
      int n = 0;
      @(posedge CLK); #3;
      P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP_2 = s2; Prescale = PW'(ps);
      BREAK_REQ = brk; DATA_VALID = 1'b1;
      #1;
      while (!DATA_READY && n < 2000) begin
         @(posedge CLK); #4;
         n++;
      end
      if (!DATA_READY) begin
         checks++; errors++;
         $display("FAIL handshake timeout got ready=%b exp=1", DATA_READY);
         DATA_VALID = 1'b0;
      end else begin
         push_frame(d, pe, pt, s2, ps);
      end
   endtask

   task automatic drop();
      @(posedge CLK); #3;
      DATA_VALID = 1'b0; BREAK_REQ = 1'b0;
      P_DATA = DW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
      STOP_2 = 1'($urandom); Prescale = PW'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() > 0 && n < 5000) begin
         @(posedge CLK);
         n++;
      end
      if (exp_q.size() > 0) begin
         checks++; errors++;
         $display("FAIL idle timeout got pending=%0d exp=0", exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(posedge CLK);
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      mon_en = 1'b1;
      #3 RST = 1'b0;
      repeat (2) @(posedge CLK);

      drive_frame(8'hA5, 1, 0, 0, 4, 0); drop(); wait_idle();
      drive_frame(8'hA5, 1, 1, 1, 4, 0); drop(); wait_idle();
      drive_frame(8'h3C, 0, 0, 0, 2, 0);
      drive_frame(8'hC3, 0, 0, 0, 2, 0); drop(); wait_idle();
      drive_frame(8'hFF, 0, 0, 0, 0, 0); drop(); wait_idle();

      // Reset in the middle of data bit 3; the remaining bits must never appear
      drive_frame(8'h5A, 0, 0, 0, 4, 0);
      repeat (18) @(posedge CLK);
      #3; RST = 1'b1; DATA_VALID = 1'b0; exp_q.delete();
      @(posedge CLK); #3; RST = 1'b0;
      wait_idle();

      for (int i = 0; i < 25; i++) begin
         drive_frame(DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     int'($urandom_range(0, 5)), 0);
         if ($urandom_range(0, 1) == 0) begin
            drop();
            repeat ($urandom_range(0, 3)) @(posedge CLK);
         end
      end
      drop(); wait_idle();

`ifdef UART_TX_BREAK_EN
      @(posedge CLK); #3;
      Prescale = PW'(3); BREAK_REQ = 1'b1; DATA_VALID = 1'b0;
      push_break(3);
      @(posedge CLK); #3; BREAK_REQ = 1'b0; Prescale = PW'(1);
      wait_idle();
      drive_frame(8'h96, 1, 0, 0, 3, 1); drop(); wait_idle();
`endif

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got pending=%0d exp=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
